dmem_arbiter: RTL and testbench

//   Shares one 4-lane byte-enabled data memory (4 x 8-bit dataMemory, word addressed) between two requesters:

---
 rtl/dmem_arbiter_if.sv | 14 +
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data memory: request bus in, grant and tagged read return out.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a 4-lane byte-enabled data memory: same-cycle grant, read data after RD_LAT cycles.
// Requesters hold their request until gnt; port 1 can lock the memory for bursts and is never starved.
module dmem_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dmem_arbiter_if.slave p0_if,
  dmem_arbiter_if.slave p1_if,
  input  logic        i_lock1,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_P0, ST_P1, ST_P1_LOCK} state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_gnt;
  logic [7:0]          r_wait_cnt;
  logic [7:0]          w_wait_nxt;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_rd;
  logic [RD_LAT-1:0]   r_tag_vld;
  logic [RD_LAT-1:0]   r_tag_port;
  logic                w_ret0;
  logic                w_ret1;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = ST_IDLE;
    if (i_rst_n) begin
      // An active lock overrides both priority and the starvation counter.
      if (r_state == ST_P1_LOCK && p1_if.req && i_lock1) begin
        w_gnt1 = 1'b1;
      end else if (p0_if.req && p1_if.req) begin
        if (CPU_PRIO != 0) begin
          w_gnt1 = (r_wait_cnt == LP_MAX_WAIT);
        end else begin
          w_gnt1 = ~r_last_gnt;
        end
        w_gnt0 = ~w_gnt1;
      end else begin
        w_gnt0 = p0_if.req;
        w_gnt1 = p1_if.req;
      end

      if (w_gnt1) begin
        w_state_nxt = i_lock1 ? ST_P1_LOCK : ST_P1;
      end else if (w_gnt0) begin
        w_state_nxt = ST_P0;
      end
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!p1_if.req || w_gnt1) begin
      w_wait_nxt = 8'd0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    o_mem_wren  = 4'd0;
    if (w_gnt0) begin
      o_mem_addr  = p0_if.addr;
      o_mem_wdata = p0_if.wdata;
      o_mem_wren  = p0_if.we;
    end else if (w_gnt1) begin
      o_mem_addr  = p1_if.addr;
      o_mem_wdata = p1_if.wdata;
      o_mem_wren  = p1_if.we;
    end
  end

  assign w_rd = (w_gnt0 && p0_if.we == 4'd0) || (w_gnt1 && p1_if.we == 4'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_wait_cnt <= 8'd0;
      r_tag_vld  <= '0;
      r_tag_port <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_gnt0 || w_gnt1) begin
        r_last_gnt <= w_gnt1;
      end
      for (int k = RD_LAT - 1; k > 0; k--) begin
        r_tag_vld[k]  <= r_tag_vld[k-1];
        r_tag_port[k] <= r_tag_port[k-1];
      end
      r_tag_vld[0]  <= w_rd;
      r_tag_port[0] <= w_gnt1;
    end
  end

  // Returned data is passed straight through from the memory in the tag's exit cycle.
  assign w_ret0 = i_rst_n && r_tag_vld[RD_LAT-1] && !r_tag_port[RD_LAT-1];
  assign w_ret1 = i_rst_n && r_tag_vld[RD_LAT-1] &&  r_tag_port[RD_LAT-1];

  assign p0_if.gnt    = w_gnt0;
  assign p1_if.gnt    = w_gnt1;
  assign p0_if.rvalid = w_ret0;
  assign p1_if.rvalid = w_ret1;
  assign p0_if.rdata  = w_ret0 ? i_mem_rdata : 32'd0;
  assign p1_if.rdata  = w_ret1 ? i_mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a priority instance with a byte-lane memory model, plus a round-robin instance.
module tb_dmem_arbiter;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        lock1;
  logic        rr_lock1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;
  logic [31:0] rr_addr, rr_wdata, rr_rdata;
  logic [3:0]  rr_wren;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter_if a0 ();
  dmem_arbiter_if a1 ();
  dmem_arbiter_if b0 ();
  dmem_arbiter_if b1 ();

  dmem_arbiter #(.RD_LAT(RD_LAT), .CPU_PRIO(1), .MAX_WAIT(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .p0_if(a0), .p1_if(a1), .i_lock1(lock1),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.RD_LAT(RD_LAT), .CPU_PRIO(0), .MAX_WAIT(8)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .p0_if(b0), .p1_if(b1), .i_lock1(rr_lock1),
    .o_mem_addr(rr_addr), .o_mem_wdata(rr_wdata), .o_mem_wren(rr_wren), .i_mem_rdata(rr_rdata)
  );

  // Byte-lane memory: synchronous read, then RD_LAT-1 extra stages.
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = 32'd0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_wren[k]) mem[mem_addr[5:0]][8*k +: 8] <= mem_wdata[8*k +: 8];
    rd_pipe[0] <= mem[mem_addr[5:0]];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];
  assign rr_rdata  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_a0(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    a0.req = req; a0.we = we; a0.addr = addr; a0.wdata = wdata;
  endtask

  task automatic set_a1(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    a1.req = req; a1.we = we; a1.addr = addr; a1.wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0; lock1 = 1'b0; rr_lock1 = 1'b0;
    set_a0(1'b1, 4'h0, 32'd0, 32'd0);
    set_a1(1'b1, 4'h0, 32'd1, 32'd0);
    b0.req = 1'b1; b0.we = 4'h0; b0.addr = 32'd0; b0.wdata = 32'd0;
    b1.req = 1'b1; b1.we = 4'h0; b1.addr = 32'd0; b1.wdata = 32'd0;

    // Reset held with both requesting
    @(negedge clk); #1;
    chk("rst_gnt0", 32'(a0.gnt), 32'd0);
    chk("rst_gnt1", 32'(a1.gnt), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(negedge clk); #1;
    chk("rst_rvalid0", 32'(a0.rvalid), 32'd0);
    chk("rst_rvalid1", 32'(a1.rvalid), 32'd0);
    chk("rst_rr_gnt0", 32'(b0.gnt), 32'd0);

    // Release: fixed priority with anti-starvation, and round-robin alternation
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("prio_gnt0_c%0d", i), 32'(a0.gnt), (i == 8) ? 32'd0 : 32'd1);
      chk($sformatf("prio_gnt1_c%0d", i), 32'(a1.gnt), (i == 8) ? 32'd1 : 32'd0);
      chk($sformatf("rr_gnt0_c%0d", i), 32'(b0.gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_gnt1_c%0d", i), 32'(b1.gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Round-robin with a single requester
    @(negedge clk); b1.req = 1'b0; a0.req = 1'b0; a1.req = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("rr_solo0_c%0d", i), 32'(b0.gnt), 32'd1);
    end
    @(negedge clk); b0.req = 1'b0; b1.req = 1'b1; #1;
    chk("rr_solo1", 32'(b1.gnt), 32'd1);
    @(negedge clk); b1.req = 1'b0;
    repeat (2) @(negedge clk);

    // Word write then read back
    set_a0(1'b1, 4'hF, 32'd5, 32'hDEADBEEF); #1;
    chk("sw_gnt0", 32'(a0.gnt), 32'd1);
    chk("sw_wren", 32'(mem_wren), 32'hF);
    chk("sw_addr", mem_addr, 32'd5);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); set_a0(1'b1, 4'h0, 32'd5, 32'd0); #1;
    chk("lw_gnt0", 32'(a0.gnt), 32'd1);
    chk("lw_wren", 32'(mem_wren), 32'd0);
    @(negedge clk); a0.req = 1'b0; #1;
    chk("lw_early", 32'(a0.rvalid), 32'd0);
    @(negedge clk); #1;
    chk("lw_rvalid0", 32'(a0.rvalid), 32'd1);
    chk("lw_rdata0", a0.rdata, 32'hDEADBEEF);
    chk("lw_rvalid1", 32'(a1.rvalid), 32'd0);
    chk("lw_rdata1", a1.rdata, 32'd0);
    @(negedge clk); #1;
    chk("lw_once", 32'(a0.rvalid), 32'd0);

    // Byte write, then back-to-back reads from both ports
    set_a0(1'b1, 4'h1, 32'd5, 32'h00000011); #1;
    chk("sb_wren", 32'(mem_wren), 32'h1);
    @(negedge clk); set_a0(1'b1, 4'h0, 32'd5, 32'd0); #1;
    chk("b2b_gnt0", 32'(a0.gnt), 32'd1);
    @(negedge clk); a0.req = 1'b0; set_a1(1'b1, 4'h0, 32'd5, 32'd0); #1;
    chk("b2b_gnt1", 32'(a1.gnt), 32'd1);
    @(negedge clk); a1.req = 1'b0; #1;
    chk("b2b_rvalid0", 32'(a0.rvalid), 32'd1);
    chk("b2b_rdata0", a0.rdata, 32'hDEADBE11);
    chk("b2b_rvalid1_early", 32'(a1.rvalid), 32'd0);
    @(negedge clk); #1;
    chk("b2b_rvalid1", 32'(a1.rvalid), 32'd1);
    chk("b2b_rdata1", a1.rdata, 32'hDEADBE11);
    chk("b2b_rvalid0_done", 32'(a0.rvalid), 32'd0);

    // Port 1 burst lock against a persistent port 0 request
    @(negedge clk); set_a1(1'b1, 4'h0, 32'd7, 32'd0); lock1 = 1'b1; #1;
    chk("lock_first", 32'(a1.gnt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); set_a0(1'b1, 4'h0, 32'd0, 32'd0); #1;
      chk($sformatf("lock_gnt1_c%0d", i), 32'(a1.gnt), 32'd1);
      chk($sformatf("lock_gnt0_c%0d", i), 32'(a0.gnt), 32'd0);
    end
    @(negedge clk); lock1 = 1'b0; #1;
    chk("unlock_gnt0", 32'(a0.gnt), 32'd1);
    chk("unlock_gnt1", 32'(a1.gnt), 32'd0);
    @(negedge clk); a0.req = 1'b0; a1.req = 1'b0;
    repeat (3) @(negedge clk);

    // Reads in flight dropped by reset
    set_a0(1'b1, 4'h0, 32'd5, 32'd0); #1;
    chk("flush_gnt0a", 32'(a0.gnt), 32'd1);
    @(negedge clk); a0.req = 1'b0; set_a1(1'b1, 4'h0, 32'd5, 32'd0); #1;
    chk("flush_gnt1", 32'(a1.gnt), 32'd1);
    @(negedge clk); a1.req = 1'b0; a0.req = 1'b1; #1;
    chk("flush_gnt0b", 32'(a0.gnt), 32'd1);
    chk("flush_first_ret", 32'(a0.rvalid), 32'd1);
    @(negedge clk); a0.req = 1'b0; rst_n = 1'b0; #1;
    chk("flush_rst_rvalid1", 32'(a1.rvalid), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk($sformatf("flush_rvalid0_c%0d", i), 32'(a0.rvalid), 32'd0);
      chk($sformatf("flush_rvalid1_c%0d", i), 32'(a1.rvalid), 32'd0);
    end
    @(negedge clk); a0.req = 1'b1; #1;
    chk("post_flush_gnt0", 32'(a0.gnt), 32'd1);
    @(negedge clk); a0.req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
